ahb_burst_seq: RTL and testbench
================================

# ahb_burst_seq

Upstream command sequencer for `ahb_bus`: accepts one burst descriptor (direction, start address, size, beat count) and expands it into single-beat requests on the `ahb_bus` user interface (`din_*` / `dout_*` handshake). Write data is streamed in per beat; read responses are streamed out with a last-beat marker. One burst is in flight at a time; a new descriptor is accepted only after the previous one completes.

## Interface
Parameters:
- `LEN_W`, 4: width of beat-count field; burst length = `cmd_len_i`+1, so 1..2^LEN_W beats.

Ports:
- `hclk` in 1: clock, all logic rising-edge.
- `hreset` in 1: **one clock; reset is synchronous and active-high**.
- `cmd_vld_i` in 1: descriptor valid.
- `cmd_rdy_o` out 1: sequencer idle, descriptor accepted when both high.
- `cmd_wr_i` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr_i` in 32: start byte address.
- `cmd_size_i` in 3: beat size, 0 = byte, 1 = half, 2 = word.
- `cmd_len_i` in LEN_W: beats minus one.
- `wdat_vld_i` in 1: write beat available.
- `wdat_rdy_o` out 1: write beat consumed.
- `wdat_i` in 32: write beat data.
- `rdat_vld_o` out 1: read beat valid.
- `rdat_rdy_i` in 1: read beat sink ready.
- `rdat_o` out 32: read beat data.
- `rdat_last_o` out 1: final read beat of burst.
- `done_o` out 1: one-cycle pulse, burst complete.
- `din_vld_o` out 1: to `ahb_bus` `din_vld_i`.
- `din_rdy_i` in 1: from `ahb_bus` `din_rdy_o`.
- `wr_en_o` out 1: to `ahb_bus` `wr_en_i`.
- `rd_en_o` out 1: to `ahb_bus` `rd_en_i`.
- `data_size_o` out 3: to `ahb_bus` `data_size_i`.
- `addr_o` out 32: to `ahb_bus` `addr_i`.
- `wdata_o` out 32: to `ahb_bus` `wdata_i`.
- `dout_vld_i` in 1: from `ahb_bus` `dout_vld_o`.
- `rdata_i` in 32: from `ahb_bus` `rdata_o`.
- `dout_rdy_o` out 1: to `ahb_bus` `dout_rdy_i`.

## Operation
- FSM: IDLE → ISSUE on `cmd_vld_i & cmd_rdy_o`; ISSUE → IDLE after last write beat handshake on `din`; ISSUE → DRAIN after last read beat issued; DRAIN → IDLE on last read response handshake.
- IDLE: `cmd_rdy_o`=1, latch descriptor. `cmd_size_i`>2 clamped to 2. Start address low bits masked to size alignment (size 1: bit0=0; size 2: bits[1:0]=0).
- ISSUE, write: `din_vld_o` = `wdat_vld_i`; `wdat_rdy_o` = `din_rdy_i`; `wdata_o` = `wdat_i`; `wr_en_o`=1, `rd_en_o`=0.
- ISSUE, read: `din_vld_o`=1; `rd_en_o`=1, `wr_en_o`=0; `wdata_o`=0.
- Beat handshake = `din_vld_o & din_rdy_i`. Each handshake: issue counter +1; address += 1<<size.
- Address increments only in bits[9:0] and wraps within the 1 KB window; bits[31:10] are held from the start address.
- Read path: combinational pass-through. `rdat_vld_o`=`dout_vld_i`, `rdat_o`=`rdata_i`, `dout_rdy_o`=`rdat_rdy_i` in ISSUE/DRAIN of a read burst, else `dout_rdy_o`=0. Response counter +1 per `dout` handshake. `rdat_last_o` is high when counter == len.
- `done_o` is registered and pulses on the cycle after the final handshake.

## Timing
- Reset: state IDLE; counters 0; `cmd_rdy_o`=0 while `hreset` is high, then 1 from the first cycle after deassertion. All other outputs 0.
- Descriptor accepted at edge N: `din_vld_o` may assert in cycle N+1. Throughput is one beat per cycle while `din_rdy_i` (and `wdat_vld_i` for writes) is held high.
- `addr_o`, `data_size_o`, `wr_en_o`, `rd_en_o` are registered and stable while `din_vld_o` is high and not yet accepted.
- `cmd_rdy_o` is re-asserted in the same cycle as `done_o`.
- A response arriving in the same cycle as the last read issue is counted; the FSM then moves directly to IDLE if it is the last response.
- `hreset` mid-burst: abandons the burst immediately. No `done_o` is produced, and outstanding responses are ignored (`dout_rdy_o`=0).

## Structure
- Package `ahb_seq_pkg`: state enum (IDLE/ISSUE/DRAIN), size encodings `SIZE_BYTE/HALF/WORD`, `KB_MASK`=10'h3FF.
- Optional sub-module `ahb_seq_addr_gen`: aligned start, 1 KB-wrapping increment. Everything else stays in one module.

## Test plan
- Write burst: addr 0x0000_1000, size 2, len 3, wdata 0xA0..0xA3, `din_rdy_i`=1 → 4 beats at addresses 0x1000/04/08/0C, `done_o` pulse 1 cycle after beat 4.
- Read burst: addr 0x0001_0002, size 1, len 1, responses 0x11, 0x22 → addresses 0x10002/0x10004; `rdat_last_o` high with 0x22 only.
- 1 KB wrap: addr 0x0000_03F8, size 2, len 3 → addresses 0x3F8, 0x3FC, 0x000, 0x004.
- Backpressure: `din_rdy_i` toggled 1010… and `wdat_vld_i` gapped → no beat dropped or duplicated, address stable while stalled.
- Reset mid read burst after 2 of 4 beats → next cycle `cmd_rdy_o`=1, all outputs 0; next burst starts cleanly.
- Size clamp/alignment: size 5, addr 0x07 → `data_size_o`=2, first `addr_o`=0x04.

Source files
------------

// File: rtl/ahb_seq_pkg.sv
// Shared types and constants for the AHB burst sequencer.
// Holds the FSM state encoding, transfer-size codes and the 1 KB address window mask.
package ahb_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   localparam logic [9:0] KB_MASK = 10'h3FF;

   // Sizes wider than the 32-bit data path collapse to a word.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      return (size > SIZE_WORD) ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/ahb_seq_addr_gen.sv
// Burst address arithmetic: aligns the start address to the beat size and
// steps the current address by one beat, wrapping inside the 1 KB window.
module ahb_seq_addr_gen
   import ahb_seq_pkg::*;
(
   input  logic [31:0] start_addr,
   input  logic [1:0]  start_size,
   input  logic [31:0] cur_addr,
   input  logic [1:0]  step_size,
   output logic [31:0] start_aligned,
   output logic [31:0] next_addr
);

   logic [9:0] step;
   logic [9:0] low_next;

   always_comb begin
      start_aligned = start_addr;
      case (start_size)
         SIZE_HALF[1:0]: start_aligned = {start_addr[31:1], 1'b0};
         SIZE_WORD[1:0]: start_aligned = {start_addr[31:2], 2'b00};
         default:        start_aligned = start_addr;
      endcase
   end

   // Upper bits never carry: the burst stays inside the starting 1 KB page.
   assign step      = 10'd1 << step_size;
   assign low_next  = (cur_addr[9:0] + step) & KB_MASK;
   assign next_addr = {cur_addr[31:10], low_next};

endmodule

// File: rtl/ahb_burst_seq.sv
// Expands one burst descriptor into single-beat ahb_bus requests, streaming
// write data in and read responses out, one burst in flight at a time.
module ahb_burst_seq
   import ahb_seq_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             cmd_vld_i,
   output logic             cmd_rdy_o,
   input  logic             cmd_wr_i,
   input  logic [31:0]      cmd_addr_i,
   input  logic [2:0]       cmd_size_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             wdat_vld_i,
   output logic             wdat_rdy_o,
   input  logic [31:0]      wdat_i,
   output logic             rdat_vld_o,
   input  logic             rdat_rdy_i,
   output logic [31:0]      rdat_o,
   output logic             rdat_last_o,
   output logic             done_o,
   output logic             din_vld_o,
   input  logic             din_rdy_i,
   output logic             wr_en_o,
   output logic             rd_en_o,
   output logic [2:0]       data_size_o,
   output logic [31:0]      addr_o,
   output logic [31:0]      wdata_o,
   input  logic             dout_vld_i,
   input  logic [31:0]      rdata_i,
   output logic             dout_rdy_o
);

   state_t           state;
   state_t           state_nxt;
   logic             done_nxt;
   logic             done_q;
   logic             wr_q;
   logic [2:0]       size_q;
   logic [LEN_W-1:0] len_q;
   logic [31:0]      addr_q;
   logic [LEN_W-1:0] issue_cnt;
   logic [LEN_W-1:0] resp_cnt;

   logic [2:0]       size_in;
   logic [31:0]      addr_start;
   logic [31:0]      addr_next;
   logic             accept;
   logic             issuing;
   logic             rd_active;
   logic             beat_hs;
   logic             resp_hs;
   logic             last_issue;
   logic             last_resp;

   assign size_in = clamp_size(cmd_size_i);

   ahb_seq_addr_gen u_addr_gen (
      .start_addr    (cmd_addr_i),
      .start_size    (size_in[1:0]),
      .cur_addr      (addr_q),
      .step_size     (size_q[1:0]),
      .start_aligned (addr_start),
      .next_addr     (addr_next)
   );

   // Reset masks every output at once so an abandoned burst goes quiet in its reset cycle.
   assign issuing   = (state == ISSUE) && !hreset;
   assign rd_active = ((state == ISSUE) || (state == DRAIN)) && !wr_q && !hreset;
   assign cmd_rdy_o = (state == IDLE) && !hreset;
   assign accept    = cmd_vld_i && cmd_rdy_o;

   assign din_vld_o   = issuing && (wr_q ? wdat_vld_i : 1'b1);
   assign wdat_rdy_o  = issuing && wr_q && din_rdy_i;
   assign wdata_o     = (issuing && wr_q) ? wdat_i : 32'd0;
   assign wr_en_o     = issuing && wr_q;
   assign rd_en_o     = issuing && !wr_q;
   assign addr_o      = issuing ? addr_q : 32'd0;
   assign data_size_o = issuing ? size_q : 3'd0;

   assign dout_rdy_o  = rd_active && rdat_rdy_i;
   assign rdat_vld_o  = rd_active && dout_vld_i;
   assign rdat_o      = rd_active ? rdata_i : 32'd0;
   assign rdat_last_o = rd_active && (resp_cnt == len_q);
   assign done_o      = done_q;

   assign beat_hs    = din_vld_o && din_rdy_i;
   assign resp_hs    = rd_active && dout_vld_i && rdat_rdy_i;
   assign last_issue = beat_hs && (issue_cnt == len_q);
   assign last_resp  = resp_hs && (resp_cnt == len_q);

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: begin
            // A read whose last response lands with its last issue skips DRAIN.
            if (last_issue) begin
               if (wr_q || last_resp) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_resp) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= IDLE;
         done_q    <= 1'b0;
         issue_cnt <= '0;
         resp_cnt  <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= done_nxt;
         if (accept) begin
            issue_cnt <= '0;
            resp_cnt  <= '0;
         end else begin
            if (beat_hs) issue_cnt <= issue_cnt + LEN_W'(1);
            if (resp_hs) resp_cnt  <= resp_cnt + LEN_W'(1);
         end
      end
   end

   // Descriptor fields carry no reset; every use is qualified by the FSM state.
   always_ff @(posedge hclk) begin
      if (accept) begin
         wr_q   <= cmd_wr_i;
         size_q <= size_in;
         len_q  <= cmd_len_i;
         addr_q <= addr_start;
      end else if (beat_hs) begin
         addr_q <= addr_next;
      end
   end

endmodule

// File: tb/tb_ahb_burst_seq.sv
// Directed bench for ahb_burst_seq: expected beats and responses are queued as
// stimulus is driven and checked when the sequencer produces them.
module tb_ahb_burst_seq;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        cmd_vld_i;
   logic        cmd_rdy_o;
   logic        cmd_wr_i;
   logic [31:0] cmd_addr_i;
   logic [2:0]  cmd_size_i;
   logic [3:0]  cmd_len_i;
   logic        wdat_vld_i;
   logic        wdat_rdy_o;
   logic [31:0] wdat_i;
   logic        rdat_vld_o;
   logic        rdat_rdy_i;
   logic [31:0] rdat_o;
   logic        rdat_last_o;
   logic        done_o;
   logic        din_vld_o;
   logic        din_rdy_i;
   logic        wr_en_o;
   logic        rd_en_o;
   logic [2:0]  data_size_o;
   logic [31:0] addr_o;
   logic [31:0] wdata_o;
   logic        dout_vld_i;
   logic [31:0] rdata_i;
   logic        dout_rdy_o;

   always #5 hclk = ~hclk;

   ahb_burst_seq #(.LEN_W(4)) dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .cmd_vld_i   (cmd_vld_i),
      .cmd_rdy_o   (cmd_rdy_o),
      .cmd_wr_i    (cmd_wr_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_size_i  (cmd_size_i),
      .cmd_len_i   (cmd_len_i),
      .wdat_vld_i  (wdat_vld_i),
      .wdat_rdy_o  (wdat_rdy_o),
      .wdat_i      (wdat_i),
      .rdat_vld_o  (rdat_vld_o),
      .rdat_rdy_i  (rdat_rdy_i),
      .rdat_o      (rdat_o),
      .rdat_last_o (rdat_last_o),
      .done_o      (done_o),
      .din_vld_o   (din_vld_o),
      .din_rdy_i   (din_rdy_i),
      .wr_en_o     (wr_en_o),
      .rd_en_o     (rd_en_o),
      .data_size_o (data_size_o),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .dout_vld_i  (dout_vld_i),
      .rdata_i     (rdata_i),
      .dout_rdy_o  (dout_rdy_o)
   );

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } rsp_t;

   beat_t       exp_beat[$];
   logic        exp_fin[$];
   rsp_t        exp_rsp[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        done_pend = 1'b0;
   logic        stall_pend = 1'b0;
   logic [31:0] stall_addr = 32'd0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called once per cycle at the falling edge; reports handshakes that will complete at the next rising edge.
   task automatic monitor(output logic dh, output logic rh);
      beat_t eb;
      beat_t ob;
      rsp_t  er;
      rsp_t  orr;
      logic  fin;
      dh = din_vld_o && din_rdy_i;
      rh = rdat_vld_o && rdat_rdy_i;
      if (!hreset) begin
         chk("done_pulse", 128'(done_o), 128'(done_pend));
         if (done_o) chk("cmd_rdy_with_done", 128'(cmd_rdy_o), 128'(1));
      end
      done_pend = 1'b0;
      if (stall_pend && din_vld_o) chk("stall_addr", 128'(addr_o), 128'(stall_addr));
      stall_pend = din_vld_o && !din_rdy_i;
      stall_addr = addr_o;
      if (dh) begin
         if (exp_beat.size() == 0) begin
            chk("beat_extra", 128'(dh), 128'(0));
         end else begin
            eb  = exp_beat.pop_front();
            fin = exp_fin.pop_front();
            ob  = {wr_en_o, rd_en_o, data_size_o, addr_o, wdata_o};
            chk("beat", 128'(ob), 128'(eb));
            if (fin) done_pend = 1'b1;
         end
      end
      if (rh) begin
         if (exp_rsp.size() == 0) begin
            chk("rsp_extra", 128'(rh), 128'(0));
         end else begin
            er  = exp_rsp.pop_front();
            orr = {rdat_last_o, rdat_o};
            chk("rsp", 128'(orr), 128'(er));
            if (er.last) done_pend = 1'b1;
         end
      end
      if (hreset) done_pend = 1'b0;
   endtask

   task automatic tick(output logic dh, output logic rh);
      @(negedge hclk);
      monitor(dh, rh);
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_tick();
      logic dh;
      logic rh;
      tick(dh, rh);
   endtask

   task automatic push_beats(input logic wr, input logic [31:0] start, input logic [2:0] size,
                             input int n, input logic [31:0] wbase);
      logic [31:0] a;
      logic [9:0]  lo;
      beat_t       b;
      a = start;
      for (int i = 0; i < n; i++) begin
         b.wr    = wr;
         b.rd    = !wr;
         b.size  = size;
         b.addr  = a;
         b.wdata = wr ? (wbase + 32'(i)) : 32'd0;
         exp_beat.push_back(b);
         exp_fin.push_back(wr && (i == n - 1));
         lo = a[9:0] + (10'd1 << size[1:0]);
         a  = {a[31:10], lo};
      end
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] len);
      logic ok;
      ok         = 1'b0;
      cmd_vld_i  = 1'b1;
      cmd_wr_i   = wr;
      cmd_addr_i = addr;
      cmd_size_i = size;
      cmd_len_i  = len;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (cmd_rdy_o) ok = 1'b1;
         idle_tick();
      end
      cmd_vld_i = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 128'(ok), 128'(1));
   endtask

   task automatic run_write(input int n, input logic [31:0] wbase, input logic toggle, input logic gap);
      int   idx;
      int   cyc;
      logic dh;
      logic rh;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 200) begin
         wdat_vld_i = !(gap && (cyc % 3 == 2));
         wdat_i     = wbase + 32'(idx);
         din_rdy_i  = !toggle || (cyc % 2 == 0);
         tick(dh, rh);
         if (dh) idx++;
         cyc++;
      end
      wdat_vld_i = 1'b0;
      din_rdy_i  = 1'b0;
      chk("write_beats", 128'(idx), 128'(n));
      idle_tick();
   endtask

   task automatic run_read(input int n, input logic [31:0] rbase, input logic toggle, input int stop_after);
      int   issued;
      int   ret;
      int   cyc;
      logic dh;
      logic rh;
      rsp_t r;
      for (int i = 0; i < n; i++) begin
         r.last = (i == n - 1);
         r.data = rbase * 32'(i + 1);
         exp_rsp.push_back(r);
      end
      issued = 0;
      ret    = 0;
      cyc    = 0;
      rdat_rdy_i = 1'b1;
      while (ret < n && cyc < 300 && !(stop_after >= 0 && issued == stop_after)) begin
         din_rdy_i  = !toggle || (cyc % 2 == 0);
         dout_vld_i = (ret < issued);
         rdata_i    = rbase * 32'(ret + 1);
         tick(dh, rh);
         if (dh) issued++;
         if (rh) ret++;
         cyc++;
      end
      din_rdy_i  = 1'b0;
      dout_vld_i = 1'b0;
      if (stop_after < 0) begin
         chk("read_resps", 128'(ret), 128'(n));
         idle_tick();
      end else begin
         chk("read_partial_issue", 128'(issued), 128'(stop_after));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      hreset     = 1'b1;
      cmd_vld_i  = 1'b0;
      cmd_wr_i   = 1'b0;
      cmd_addr_i = 32'd0;
      cmd_size_i = 3'd0;
      cmd_len_i  = 4'd0;
      wdat_vld_i = 1'b0;
      wdat_i     = 32'd0;
      rdat_rdy_i = 1'b0;
      din_rdy_i  = 1'b0;
      dout_vld_i = 1'b0;
      rdata_i    = 32'd0;

      @(posedge hclk);
      #1;
      idle_tick();
      chk("rst_cmd_rdy_held", 128'(cmd_rdy_o), 128'(0));
      chk("rst_din_vld", 128'(din_vld_o), 128'(0));
      chk("rst_done", 128'(done_o), 128'(0));
      hreset = 1'b0;
      #1;
      chk("rst_cmd_rdy_release", 128'(cmd_rdy_o), 128'(1));
      chk("rst_outputs", 128'({din_vld_o, wr_en_o, rd_en_o, dout_rdy_o, rdat_vld_o, addr_o}), 128'(0));
      idle_tick();

      // Write burst, word size, full throughput.
      send_cmd(1'b1, 32'h0000_1000, 3'd2, 4'd3);
      push_beats(1'b1, 32'h0000_1000, 3'd2, 4, 32'hA0);
      run_write(4, 32'hA0, 1'b0, 1'b0);
      chk("idle_after_write", 128'(cmd_rdy_o), 128'(1));

      // Read burst, halfword size.
      send_cmd(1'b0, 32'h0001_0002, 3'd1, 4'd1);
      push_beats(1'b0, 32'h0001_0002, 3'd1, 2, 32'd0);
      run_read(2, 32'h11, 1'b0, -1);

      // 1 KB window wrap.
      send_cmd(1'b1, 32'h0000_03F8, 3'd2, 4'd3);
      push_beats(1'b1, 32'h0000_03F8, 3'd2, 4, 32'hB0);
      run_write(4, 32'hB0, 1'b0, 1'b0);

      // Backpressure on both din_rdy_i and write data.
      send_cmd(1'b1, 32'h0000_5040, 3'd0, 4'd5);
      push_beats(1'b1, 32'h0000_5040, 3'd0, 6, 32'hC0);
      run_write(6, 32'hC0, 1'b1, 1'b1);
      send_cmd(1'b0, 32'h0000_6100, 3'd2, 4'd2);
      push_beats(1'b0, 32'h0000_6100, 3'd2, 3, 32'd0);
      run_read(3, 32'h21, 1'b1, -1);

      // Reset after two of four read beats; a stray response must be ignored.
      send_cmd(1'b0, 32'h0000_2000, 3'd2, 4'd3);
      push_beats(1'b0, 32'h0000_2000, 3'd2, 4, 32'd0);
      run_read(4, 32'h31, 1'b0, 2);
      dout_vld_i = 1'b1;
      rdata_i    = 32'hDEAD;
      rdat_rdy_i = 1'b1;
      din_rdy_i  = 1'b1;
      hreset     = 1'b1;
      #1;
      chk("midrst_cmd_rdy", 128'(cmd_rdy_o), 128'(0));
      chk("midrst_quiet", 128'({din_vld_o, dout_rdy_o, rdat_vld_o}), 128'(0));
      idle_tick();
      hreset = 1'b0;
      exp_beat.delete();
      exp_fin.delete();
      exp_rsp.delete();
      #1;
      chk("postrst_cmd_rdy", 128'(cmd_rdy_o), 128'(1));
      chk("postrst_outputs",
          128'({din_vld_o, wr_en_o, rd_en_o, dout_rdy_o, rdat_vld_o, rdat_last_o, done_o, addr_o, rdat_o}),
          128'(0));
      dout_vld_i = 1'b0;
      din_rdy_i  = 1'b0;
      idle_tick();

      // Size clamp and start alignment.
      send_cmd(1'b1, 32'h0000_0007, 3'd5, 4'd0);
      push_beats(1'b1, 32'h0000_0004, 3'd2, 1, 32'h5A);
      run_write(1, 32'h5A, 1'b0, 1'b0);

      // Clean read burst after the reset sequence.
      send_cmd(1'b0, 32'h0000_7010, 3'd0, 4'd2);
      push_beats(1'b0, 32'h0000_7010, 3'd0, 3, 32'd0);
      run_read(3, 32'h41, 1'b0, -1);

      idle_tick();
      chk("beats_drained", 128'(exp_beat.size()), 128'(0));
      chk("rsps_drained", 128'(exp_rsp.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
